// File: rtl/logic_unit_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe_if
//  Purpose  : Handshake bundle for logic_unit_pipe. The input beat channel and
//             the result channel each use valid/ready; busy flags an open fold.
//  Revision : 1.0  initial release
// ============================================================================
interface logic_unit_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2:0]         in_op;
  logic               in_acc;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [COUNT_W-1:0] out_beats;
  logic               busy;

  // Producer/consumer side: drives beats and accepts results
  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats, busy
  );

  // Logic unit side
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats, busy
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe
//  Purpose  : Registered bitwise logic ALU (8 functions) with valid/ready on
//             both sides and a fold mode that reduces a burst of beats through
//             the function latched on the burst's first beat.
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  logic_unit_pipe_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] C_CNT_ONE = COUNT_W'(1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_acc;
  logic [2:0]           r_op_q;
  logic [COUNT_W-1:0]   r_cnt;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic [COUNT_W-1:0]   r_out_beats;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_in_accum;
  logic [WIDTH-1:0]     w_x;
  logic [2:0]           w_op;
  logic [WIDTH-1:0]     w_result;
  logic [COUNT_W-1:0]   w_cnt_next;
  logic                 w_issue;
  logic [COUNT_W-1:0]   w_issue_beats;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = ~(x ^ y);
      3'd5:    r = x ^ y;
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  // A new beat can enter whenever the result slot is empty or being emptied now
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_in_accum = (r_state == ST_ACCUM);

  // Inside a fold the left operand and function come from the burst's own state
  assign w_x        = w_in_accum ? r_acc  : bus.in_a;
  assign w_op       = w_in_accum ? r_op_q : bus.in_op;
  assign w_result   = apply_op(w_op, w_x, bus.in_b);

  // Beat count saturates instead of wrapping so long bursts report the maximum
  assign w_cnt_next = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_ONE;

  // A beat produces a result when it is single-shot, a one-beat fold, or a fold's last beat
  assign w_issue       = w_accept && (w_in_accum ? bus.in_last : (!bus.in_acc || bus.in_last));
  assign w_issue_beats = w_in_accum ? w_cnt_next : C_CNT_ONE;

  // Burst FSM: opens a fold on a non-final accumulate beat, closes on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_op_q  <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_acc && !bus.in_last) begin
            r_acc   <= w_result;
            r_op_q  <= bus.in_op;
            r_cnt   <= C_CNT_ONE;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_cnt <= w_cnt_next;
          if (bus.in_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_result;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result register: reload on issue, otherwise drop valid once the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_beats <= w_issue_beats;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_beats = r_out_beats;
  assign bus.busy      = w_in_accum;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_pipe
//  Purpose  : Self-checking bench for logic_unit_pipe; two instances (COUNT_W=8
//             and COUNT_W=2) share one stimulus stream and one reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic       in_valid, in_acc, in_last, out_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;

  logic_unit_pipe_if #(.WIDTH(8), .COUNT_W(8)) bus8 ();
  logic_unit_pipe_if #(.WIDTH(8), .COUNT_W(2)) bus2 ();

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  logic_unit_pipe #(.WIDTH(8), .COUNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign bus8.in_valid  = in_valid;
  assign bus8.in_a      = in_a;
  assign bus8.in_b      = in_b;
  assign bus8.in_op     = in_op;
  assign bus8.in_acc    = in_acc;
  assign bus8.in_last   = in_last;
  assign bus8.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_a      = in_a;
  assign bus2.in_b      = in_b;
  assign bus2.in_op     = in_op;
  assign bus2.in_acc    = in_acc;
  assign bus2.in_last   = in_last;
  assign bus2.out_ready = out_ready;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: burst state and the pending result, beat count kept unbounded
  bit       m_open;
  bit [7:0] m_acc;
  bit [2:0] m_op;
  int       m_cnt;
  bit       m_ov;
  bit [7:0] m_od;
  int       m_ob;

  function automatic bit [7:0] f(input bit [2:0] op, input bit [7:0] x, input bit [7:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~(x & y);
      3'd3: return ~(x | y);
      3'd4: return ~(x ^ y);
      3'd5: return x ^ y;
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_open = 0; m_acc = 0; m_op = 0; m_cnt = 0;
    m_ov = 0; m_od = 0; m_ob = 0;
  endtask

  task automatic model_edge();
    bit       accepted, took, issued;
    bit [7:0] r;
    int       beats;
    accepted = in_valid && (!m_ov || out_ready);
    took     = m_ov && out_ready;
    issued   = 0;
    r        = 0;
    beats    = 0;
    if (accepted) begin
      if (!m_open) begin
        r = f(in_op, in_a, in_b);
        if (!in_acc || in_last) begin
          issued = 1; beats = 1;
        end else begin
          m_open = 1; m_acc = r; m_op = in_op; m_cnt = 1;
        end
      end else begin
        r = f(m_op, m_acc, in_b);
        m_cnt = m_cnt + 1;
        if (in_last) begin
          issued = 1; beats = m_cnt; m_open = 0;
        end else begin
          m_acc = r;
        end
      end
    end
    if (issued) begin
      m_ov = 1; m_od = r; m_ob = beats;
    end else if (took) begin
      m_ov = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out_valid8", 32'(bus8.out_valid), 32'(m_ov));
    check("out_valid2", 32'(bus2.out_valid), 32'(m_ov));
    check("in_ready8",  32'(bus8.in_ready),  32'(!m_ov || out_ready));
    check("in_ready2",  32'(bus2.in_ready),  32'(!m_ov || out_ready));
    check("busy8",      32'(bus8.busy),      32'(m_open));
    check("busy2",      32'(bus2.busy),      32'(m_open));
    if (m_ov) begin
      check("out_data8",  32'(bus8.out_data),  32'(m_od));
      check("out_data2",  32'(bus2.out_data),  32'(m_od));
      check("out_beats8", 32'(bus8.out_beats), 32'(sat(m_ob, 255)));
      check("out_beats2", 32'(bus2.out_beats), 32'(sat(m_ob, 3)));
    end
  endtask

  // One clock: model advances on the edge, outputs compared half a cycle later
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic beat(input bit [7:0] a, input bit [7:0] b, input bit [2:0] op,
                      input bit acc, input bit last);
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_busy",      32'(bus8.busy),      32'd0);
    check("rst_busy2",     32'(bus2.busy),      32'd0);
    #1 rst = 1'b0;
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 8'h4A; sweep_exp[1] = 8'hDF; sweep_exp[2] = 8'hB5; sweep_exp[3] = 8'h20;
    sweep_exp[4] = 8'h6A; sweep_exp[5] = 8'h95; sweep_exp[6] = 8'h35; sweep_exp[7] = 8'hCA;

    rst = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_acc = 0; in_last = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_data",  32'(bus8.out_data),  32'd0);
    check("reset_beats", 32'(bus8.out_beats), 32'd0);
    check_all();
    rst = 1'b0;

    // Single AND
    out_ready = 1;
    beat(8'hF0, 8'h3C, 3'd0, 0, 0);
    step();
    check("and_valid", 32'(bus8.out_valid), 32'd1);
    check("and_data",  32'(bus8.out_data),  32'h30);
    check("and_beats", 32'(bus8.out_beats), 32'd1);

    // Op sweep back-to-back
    for (int i = 0; i < 8; i++) begin
      beat(8'hCA, 8'h5F, 3'(i), 0, 0);
      step();
      check("sweep_data", 32'(bus8.out_data), 32'(sweep_exp[i]));
    end
    in_valid = 0;
    step();

    // XOR fold of three beats
    beat(8'h01, 8'h02, 3'd5, 1, 0); step();
    check("fold_busy", 32'(bus8.busy), 32'd1);
    beat(8'hEE, 8'h04, 3'd2, 1, 0); step();
    beat(8'hEE, 8'h08, 3'd0, 1, 1); step();
    check("fold_data",  32'(bus8.out_data),  32'h0F);
    check("fold_beats", 32'(bus8.out_beats), 32'd3);
    check("fold_idle",  32'(bus8.busy),      32'd0);
    in_valid = 0;
    step();

    // Backpressure: second beat waits until the first is taken
    out_ready = 0;
    beat(8'h11, 8'h22, 3'd1, 0, 0); step();
    check("bp_ready", 32'(bus8.in_ready), 32'd0);
    beat(8'h0F, 8'hF0, 3'd5, 0, 0); step();
    check("bp_hold1", 32'(bus8.out_data), 32'h33);
    step();
    check("bp_hold2", 32'(bus8.out_data), 32'h33);
    out_ready = 1;
    step();
    check("bp_second", 32'(bus8.out_data), 32'hFF);
    in_valid = 0;
    step();
    check("bp_drained", 32'(bus8.out_valid), 32'd0);

    // Reset in the middle of a fold
    beat(8'h03, 8'h04, 3'd1, 1, 0); step();
    beat(8'h00, 8'h08, 3'd1, 1, 0); step();
    in_valid = 0;
    async_reset_pulse();
    beat(8'h11, 8'h22, 3'd1, 0, 0); step();
    check("post_rst_data",  32'(bus8.out_data),  32'h33);
    check("post_rst_beats", 32'(bus8.out_beats), 32'd1);
    in_valid = 0;
    step();

    // Five-beat OR fold: beat count saturates at 3 on the narrow counter
    beat(8'h00, 8'h01, 3'd1, 1, 0); step();
    beat(8'h00, 8'h02, 3'd1, 1, 0); step();
    beat(8'h00, 8'h04, 3'd1, 1, 0); step();
    beat(8'h00, 8'h08, 3'd1, 1, 0); step();
    beat(8'h00, 8'h10, 3'd1, 1, 1); step();
    check("sat_data",   32'(bus2.out_data),  32'h1F);
    check("sat_beats2", 32'(bus2.out_beats), 32'd3);
    check("sat_beats8", 32'(bus8.out_beats), 32'd5);
    in_valid = 0;
    step();

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 3'($urandom);
      in_acc    = ($urandom_range(0, 2) != 0);
      in_last   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
